// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU fetch/data request ports and the shared memory port.
// The arbiter uses the slave view; the environment (core + bridge) uses master.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // instruction-fetch port
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_ok;

  // load/store port
  logic              data_req;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_ok;

  // shared memory port
  logic              mem_req;
  logic              mem_wr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wstrb, data_addr, data_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output inst_rdata, inst_ok, data_rdata, data_ok,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wstrb, data_addr, data_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  inst_rdata, inst_ok, data_rdata, data_ok,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between CPU fetch and load/store: one transaction at a
// time, data wins over fetch, with a run limit so fetch cannot be starved.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_DATA_RUN = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_DATA_RUN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  state_t            state_q,      state_d;
  owner_t            owner_q,      owner_d;
  logic [CNT_W-1:0]  run_cnt_q,    run_cnt_d;
  logic              mem_req_q,    mem_req_d;
  logic              mem_wr_q,     mem_wr_d;
  logic [STRB_W-1:0] mem_wstrb_q,  mem_wstrb_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              inst_ok_q,    inst_ok_d;
  logic              data_ok_q,    data_ok_d;

  // Fetch has waited through a full run of data grants and must go next.
  logic inst_starved_c;
  assign inst_starved_c = bus.inst_req && (run_cnt_q == RUN_MAX);

  // Next-state, grant and completion logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    run_cnt_d    = run_cnt_q;
    mem_req_d    = 1'b0;
    mem_wr_d     = mem_wr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.data_req && !inst_starved_c) begin
          state_d     = S_ADDR;
          owner_d     = OWN_DATA;
          mem_req_d   = 1'b1;
          mem_wr_d    = |bus.data_wstrb;
          mem_wstrb_d = bus.data_wstrb;
          mem_addr_d  = bus.data_addr;
          mem_wdata_d = bus.data_wdata;
          // Only grants that make fetch wait count towards the run.
          if (bus.inst_req) begin
            run_cnt_d = (run_cnt_q < RUN_MAX) ? run_cnt_q + CNT_W'(1) : run_cnt_q;
          end else begin
            run_cnt_d = '0;
          end
        end else if (bus.inst_req) begin
          state_d     = S_ADDR;
          owner_d     = OWN_INST;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_wstrb_d = '0;
          mem_addr_d  = bus.inst_addr;
          mem_wdata_d = '0;
          run_cnt_d   = '0;
        end
      end

      S_ADDR: begin
        // A data_ok coinciding with addr_ok belongs to nothing here and is dropped.
        if (bus.mem_addr_ok) begin
          state_d = S_DATA;
        end else begin
          mem_req_d = 1'b1;
        end
      end

      S_DATA: begin
        if (bus.mem_data_ok) begin
          state_d = S_IDLE;
          if (owner_q == OWN_DATA) begin
            data_ok_d    = 1'b1;
            data_rdata_d = bus.mem_rdata;
          end else begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = bus.mem_rdata;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      run_cnt_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      run_cnt_q    <= run_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.inst_ok    = inst_ok_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.data_ok    = data_ok_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, checked
// each cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int          MAX_RUN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_RUN(MAX_RUN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // Transaction model: the one outstanding transfer and the fairness counter.
  bit          outstanding = 0, accepted = 0, cur_d = 0;
  logic        cur_wr;
  logic [3:0]  cur_strb;
  logic [31:0] cur_addr, cur_wdata;
  int          run = 0, acnt = 0, dcnt = 0;
  logic [31:0] exp_ird = '0, exp_drd = '0;
  bit          drd_known = 1;
  logic        glog[$];

  // Environment knobs.
  bit          mem_auto = 0, rand_dly = 0, mem_noise = 0, rd_fixed = 0;
  int          addr_dly = 0, data_dly = 0;
  logic [31:0] rd_val = '0;
  bit          i_en = 0, d_en = 0, i_hold = 0, d_hold = 0, rand_drop = 0;
  int          i_gap = 0, d_gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_mem_req"},    bus.mem_req, 1'b0);
    chk1({tag, "_mem_wr"},     bus.mem_wr, 1'b0);
    chk ({tag, "_mem_wstrb"},  32'(bus.mem_wstrb), 32'h0);
    chk ({tag, "_mem_addr"},   bus.mem_addr, 32'h0);
    chk ({tag, "_mem_wdata"},  bus.mem_wdata, 32'h0);
    chk1({tag, "_inst_ok"},    bus.inst_ok, 1'b0);
    chk1({tag, "_data_ok"},    bus.data_ok, 1'b0);
    chk ({tag, "_inst_rdata"}, bus.inst_rdata, 32'h0);
    chk ({tag, "_data_rdata"}, bus.data_rdata, 32'h0);
  endtask

  task automatic new_inst();
    bus.inst_req  = 1'b1;
    bus.inst_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_data();
    bus.data_req   = 1'b1;
    bus.data_wstrb = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    bus.data_addr  = $urandom & 32'hFFFF_FFFC;
    bus.data_wdata = $urandom;
  endtask

  // One clock: advance the model on what was driven last cycle, check outputs,
  // then drive requesters and memory for the new cycle.
  task automatic step();
    logic        pi, pd, paok, pdok;
    logic [31:0] pia, pda, pdw, prd;
    logic [3:0]  pds;
    bit          was_out, was_acc, done;
    pi = bus.inst_req;  pia = bus.inst_addr;
    pd = bus.data_req;  pda = bus.data_addr; pds = bus.data_wstrb; pdw = bus.data_wdata;
    paok = bus.mem_addr_ok; pdok = bus.mem_data_ok; prd = bus.mem_rdata;
    @(posedge clk);
    #1;
    cyc++;

    was_out = outstanding;
    was_acc = accepted;
    done    = was_out && was_acc && (pdok === 1'b1);
    if (was_out && !was_acc && paok === 1'b1) begin
      accepted = 1;
      dcnt = rand_dly ? int'($urandom_range(0, 8)) : data_dly;
    end
    if (done) outstanding = 0;
    if (!was_out && (pi || pd)) begin
      if (pd && !(pi && run == MAX_RUN)) begin
        cur_d = 1; cur_wr = (pds != 4'h0); cur_strb = pds; cur_addr = pda; cur_wdata = pdw;
        run = pi ? ((run < MAX_RUN) ? run + 1 : run) : 0;
      end else begin
        cur_d = 0; cur_wr = 1'b0; cur_strb = 4'h0; cur_addr = pia; cur_wdata = '0;
        run = 0;
      end
      outstanding = 1;
      accepted    = 0;
      acnt = rand_dly ? int'($urandom_range(0, 5)) : addr_dly;
      glog.push_back(cur_d);
      if (rand_drop && $urandom_range(0, 7) == 0) begin
        if (cur_d) bus.data_req = 1'b0;
        else       bus.inst_req = 1'b0;
      end
    end

    chk1("mem_req", bus.mem_req, outstanding && !accepted);
    chk1("inst_ok", bus.inst_ok, done && !cur_d);
    chk1("data_ok", bus.data_ok, done && cur_d);
    if (done && !cur_d) exp_ird = prd;
    if (done && cur_d) begin
      drd_known = !cur_wr;
      exp_drd   = prd;
    end
    chk("inst_rdata", bus.inst_rdata, exp_ird);
    if (drd_known) chk("data_rdata", bus.data_rdata, exp_drd);
    if (outstanding && !accepted) begin
      chk1("mem_wr", bus.mem_wr, cur_wr);
      chk ("mem_wstrb", 32'(bus.mem_wstrb), 32'(cur_strb));
      chk ("mem_addr", bus.mem_addr, cur_addr);
      if (cur_d) chk("mem_wdata", bus.mem_wdata, cur_wdata);
    end

    if (done) begin
      if (cur_d) begin
        if (d_hold) new_data();
        else begin bus.data_req = 1'b0; d_gap = int'($urandom_range(0, 4)); end
      end else begin
        if (i_hold) new_inst();
        else begin bus.inst_req = 1'b0; i_gap = int'($urandom_range(0, 4)); end
      end
    end
    if (i_en && !bus.inst_req && !(outstanding && !cur_d)) begin
      if (i_gap == 0) new_inst(); else i_gap--;
    end
    if (d_en && !bus.data_req && !(outstanding && cur_d)) begin
      if (d_gap == 0) new_data(); else d_gap--;
    end

    if (mem_auto) begin
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b0;
      bus.mem_rdata   = rd_fixed ? rd_val : $urandom;
      if (outstanding && !accepted) begin
        if (acnt == 0) bus.mem_addr_ok = 1'b1; else acnt--;
      end else if (outstanding) begin
        if (dcnt == 0) bus.mem_data_ok = 1'b1; else dcnt--;
      end else if (mem_noise) begin
        bus.mem_addr_ok = 1'($urandom);
        bus.mem_data_ok = 1'($urandom);
      end
    end
  endtask

  task automatic wait_ok(input bit want_d, output int at);
    at = -1;
    for (int k = 0; k < 64; k++) begin
      step();
      if ((want_d ? bus.data_ok : bus.inst_ok) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic quiesce();
    i_en = 0; d_en = 0; i_hold = 0; d_hold = 0; rand_drop = 0; mem_noise = 0;
    i_gap = 0; d_gap = 0;
    for (int k = 0; k < 100; k++) begin
      if (!(outstanding && !cur_d)) bus.inst_req = 1'b0;
      if (!(outstanding && cur_d))  bus.data_req = 1'b0;
      if (!outstanding) break;
      step();
    end
    step();
    chk1("quiesce_idle", outstanding, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int          t, n0;
    logic [9:0]  exp_pat;

    // Reset held with random inputs.
    bus.inst_req = 0; bus.inst_addr = '0; bus.data_req = 0; bus.data_wstrb = '0;
    bus.data_addr = '0; bus.data_wdata = '0;
    bus.mem_addr_ok = 0; bus.mem_data_ok = 0; bus.mem_rdata = '0;
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.inst_req = 1'($urandom);   bus.inst_addr = $urandom;
      bus.data_req = 1'($urandom);   bus.data_wstrb = 4'($urandom);
      bus.data_addr = $urandom;      bus.data_wdata = $urandom;
      bus.mem_addr_ok = 1'($urandom); bus.mem_data_ok = 1'($urandom); bus.mem_rdata = $urandom;
      @(posedge clk);
      #1;
      chk_zero("reset");
    end
    bus.inst_req = 0; bus.data_req = 0; bus.mem_addr_ok = 0; bus.mem_data_ok = 0;
    rst = 1'b1;
    mem_auto = 1;
    for (int k = 0; k < 3; k++) step();

    // Single fetch.
    rd_fixed = 1; rd_val = 32'h3C1D_0000;
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0000;
    n0 = cyc;
    step();
    chk1("fetch_mem_req", bus.mem_req, 1'b1);
    chk ("fetch_mem_addr", bus.mem_addr, 32'hBFC0_0000);
    chk1("fetch_mem_wr", bus.mem_wr, 1'b0);
    wait_ok(0, t);
    chk("fetch_latency", 32'(t), 32'(n0 + 3));
    chk("fetch_rdata", bus.inst_rdata, 32'h3C1D_0000);
    rd_fixed = 0;
    step();

    // Store.
    bus.data_req = 1'b1; bus.data_wstrb = 4'b0011;
    bus.data_addr = 32'h8000_1004; bus.data_wdata = 32'hDEAD_BEEF;
    n0 = cyc;
    step();
    chk1("store_mem_wr", bus.mem_wr, 1'b1);
    chk ("store_mem_wstrb", 32'(bus.mem_wstrb), 32'h3);
    chk ("store_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk ("store_mem_addr", bus.mem_addr, 32'h8000_1004);
    wait_ok(1, t);
    chk("store_latency", 32'(t), 32'(n0 + 3));
    step();

    // Contention with 1-cycle memory: four data grants then one fetch.
    glog.delete();
    new_inst(); new_data();
    i_hold = 1; d_hold = 1;
    for (int k = 0; k < 200 && glog.size() < 10; k++) step();
    exp_pat = 10'b11110_11110;
    for (int i = 0; i < 10; i++)
      chk1("contention_order", (i < glog.size()) ? glog[i] : 1'bx, exp_pat[9-i]);
    quiesce();

    // Memory stalls: address accepted after 5 extra cycles, data after 7 more.
    addr_dly = 5; data_dly = 7;
    bus.data_req = 1'b1; bus.data_wstrb = 4'h0;
    bus.data_addr = 32'h8000_2000; bus.data_wdata = 32'h1234_5678;
    n0 = cyc;
    wait_ok(1, t);
    chk("stall_latency", 32'(t), 32'(n0 + 15));
    addr_dly = 0; data_dly = 0;
    step();

    // Reset while waiting for read data.
    data_dly = 6;
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0010;
    for (int k = 0; k < 10 && !(outstanding && accepted); k++) step();
    chk1("rst_mid_in_data", outstanding && accepted, 1'b1);
    step();
    rst = 1'b0;
    #2;
    chk_zero("rst_mid");
    mem_auto = 0;
    bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("rst_mid_hold");
    rst = 1'b1;
    outstanding = 0; accepted = 0; run = 0;
    exp_ird = '0; exp_drd = '0; drd_known = 1;
    step();
    bus.mem_data_ok = 1'b0;
    step();
    mem_auto = 1; data_dly = 0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0020;
    n0 = cyc;
    wait_ok(0, t);
    chk("rst_restart_latency", 32'(t), 32'(n0 + 3));
    step();

    // Random: both requesters saturating, random memory timing and idle noise.
    rand_dly = 1; mem_noise = 1;
    i_en = 1; d_en = 1; i_hold = 1; d_hold = 1;
    for (int k = 0; k < 1500; k++) step();
    quiesce();

    // Random: bursty requesters that sometimes drop req after the grant.
    mem_noise = 1; rand_drop = 1;
    i_en = 1; d_en = 1;
    for (int k = 0; k < 1500; k++) step();
    quiesce();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
